// File: rtl/jtkcpu_stack_seq.sv
// KCPU stack transfer sequencer: walks a register mask and issues one bus
// transaction per register for push, pull, RTI and fast-interrupt frames.
module jtkcpu_stack_seq #(
  parameter int unsigned RTI_E_BIT = 7,
  parameter logic [7:0]  FIRQ_MASK = 8'h81
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        psh_go,
  input  logic        pul_go,
  input  logic        psh_all,
  input  logic        psh_fast,
  input  logic        rti,
  input  logic [7:0]  postbyte,
  input  logic [15:0] sp_in,
  input  logic [15:0] rdata,
  output logic [2:0]  rsel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_16,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din,
  input  logic        mem_ack,
  output logic        pul_we,
  output logic [2:0]  pul_sel,
  output logic [15:0] pul_data,
  output logic        sp_we,
  output logic [15:0] sp_out,
  output logic        stack_busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_WAIT = 3'd2,
    ST_UPD  = 3'd3,
    ST_END  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  mask_r, mask_s;
  logic        push_r, push_s;
  logic        rti_r, rti_s;
  logic [15:0] sp_r, sp_s;
  logic [15:0] din_r, din_s;

  logic [2:0]  rsel_s, pul_sel_s;
  logic        mem_req_s, mem_we_s, mem_16_s;
  logic [15:0] mem_addr_s, mem_dout_s, pul_data_s, sp_out_s;
  logic        pul_we_s, sp_we_s, busy_s, done_s;

  logic        start_go_s, start_push_s, start_rti_s;
  logic [7:0]  start_mask_s;
  logic [15:0] size_s, sp_dec_s, sp_inc_s;
  logic [7:0]  rti_or_s, upd_mask_s;

  // Push walks the mask from the top bit down, pull from the bottom bit up.
  function automatic logic [2:0] pick_bit(input logic [7:0] m, input logic hi_first);
    logic [2:0] b;
    b = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[hi_first ? i : 7 - i]) b = 3'(hi_first ? i : 7 - i);
    end
    return b;
  endfunction

  assign size_s     = rsel[2] ? 16'd2 : 16'd1;
  assign sp_dec_s   = sp_r - size_s;
  assign sp_inc_s   = sp_r + size_s;
  assign rti_or_s   = (rti_r && (rsel == 3'd0)) ?
                      (din_r[RTI_E_BIT] ? 8'hFE : 8'h80) : 8'h00;
  assign upd_mask_s = (mask_r & ~(8'd1 << rsel)) | rti_or_s;

  // Start arbitration: rti > psh_all > psh_fast > psh_go > pul_go
  always_comb begin
    start_go_s   = 1'b1;
    start_mask_s = mask_r;
    start_push_s = push_r;
    start_rti_s  = 1'b0;
    if (rti) begin
      start_mask_s = 8'h01;
      start_push_s = 1'b0;
      start_rti_s  = 1'b1;
    end else if (psh_all) begin
      start_mask_s = 8'hFF;
      start_push_s = 1'b1;
    end else if (psh_fast) begin
      start_mask_s = FIRQ_MASK;
      start_push_s = 1'b1;
    end else if (psh_go) begin
      start_mask_s = postbyte;
      start_push_s = 1'b1;
    end else if (pul_go) begin
      start_mask_s = postbyte;
      start_push_s = 1'b0;
    end else begin
      start_go_s = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    mask_s     = mask_r;
    push_s     = push_r;
    rti_s      = rti_r;
    sp_s       = sp_r;
    din_s      = din_r;
    rsel_s     = rsel;
    mem_req_s  = mem_req;
    mem_we_s   = mem_we;
    mem_16_s   = mem_16;
    mem_addr_s = mem_addr;
    mem_dout_s = mem_dout;
    pul_sel_s  = pul_sel;
    pul_data_s = pul_data;
    sp_out_s   = sp_out;
    busy_s     = stack_busy;
    pul_we_s   = 1'b0;
    sp_we_s    = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_go_s) begin
          mask_s  = start_mask_s;
          push_s  = start_push_s;
          rti_s   = start_rti_s;
          sp_s    = sp_in;
          rsel_s  = pick_bit(start_mask_s, start_push_s);
          busy_s  = 1'b1;
          state_s = ST_SEL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEL: begin
        if (mask_r == 8'd0) begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_END;
        end else begin
          // rsel was set one cycle earlier, so rdata already reflects it
          rsel_s     = pick_bit(mask_r, push_r);
          mem_req_s  = 1'b1;
          mem_we_s   = push_r;
          mem_16_s   = rsel[2];
          mem_addr_s = push_r ? sp_dec_s : sp_r;
          mem_dout_s = push_r ? rdata : 16'd0;
          state_s    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          din_s     = mem_din;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          state_s   = ST_UPD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_UPD: begin
        sp_s     = push_r ? sp_dec_s : sp_inc_s;
        sp_out_s = push_r ? sp_dec_s : sp_inc_s;
        sp_we_s  = 1'b1;
        if (!push_r) begin
          pul_we_s   = 1'b1;
          pul_sel_s  = rsel;
          pul_data_s = rsel[2] ? din_r : {8'd0, din_r[7:0]};
        end else begin
          pul_we_s = 1'b0;
        end
        mask_s  = upd_mask_s;
        rsel_s  = pick_bit(upd_mask_s, push_r);
        state_s = ST_SEL;
      end
      ST_END: begin
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, advanced only on cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mask_r     <= 8'd0;
      push_r     <= 1'b0;
      rti_r      <= 1'b0;
      sp_r       <= 16'd0;
      din_r      <= 16'd0;
      rsel       <= 3'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_16     <= 1'b0;
      mem_addr   <= 16'd0;
      mem_dout   <= 16'd0;
      pul_we     <= 1'b0;
      pul_sel    <= 3'd0;
      pul_data   <= 16'd0;
      sp_we      <= 1'b0;
      sp_out     <= 16'd0;
      stack_busy <= 1'b0;
      done       <= 1'b0;
    end else if (cen) begin
      state_r    <= state_s;
      mask_r     <= mask_s;
      push_r     <= push_s;
      rti_r      <= rti_s;
      sp_r       <= sp_s;
      din_r      <= din_s;
      rsel       <= rsel_s;
      mem_req    <= mem_req_s;
      mem_we     <= mem_we_s;
      mem_16     <= mem_16_s;
      mem_addr   <= mem_addr_s;
      mem_dout   <= mem_dout_s;
      pul_we     <= pul_we_s;
      pul_sel    <= pul_sel_s;
      pul_data   <= pul_data_s;
      sp_we      <= sp_we_s;
      sp_out     <= sp_out_s;
      stack_busy <= busy_s;
      done       <= done_s;
    end
  end

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Scoreboard bench for jtkcpu_stack_seq: a reference model queues expected bus
// transactions, register writes and SP updates; monitors pop and compare them.
module tb_jtkcpu_stack_seq;

  logic        clk, rst, cen;
  logic        psh_go, pul_go, psh_all, psh_fast, rti;
  logic [7:0]  postbyte;
  logic [15:0] sp_in, rdata, mem_din;
  logic        mem_ack;
  logic [2:0]  rsel, pul_sel;
  logic        mem_req, mem_we, mem_16, pul_we, sp_we, stack_busy, done;
  logic [15:0] mem_addr, mem_dout, pul_data, sp_out;

  logic [15:0] regs [8];
  logic [7:0]  mem  [65536];

  logic [33:0] exp_bus [$];
  logic [18:0] exp_pul [$];
  logic [15:0] exp_sp  [$];

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [15:0] exp_sp_final;
  logic cen_rand = 1'b0;
  logic resp_en = 1'b1;

  jtkcpu_stack_seq dut (
    .clk(clk), .rst(rst), .cen(cen),
    .psh_go(psh_go), .pul_go(pul_go), .psh_all(psh_all), .psh_fast(psh_fast), .rti(rti),
    .postbyte(postbyte), .sp_in(sp_in), .rdata(rdata), .rsel(rsel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_16(mem_16), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack),
    .pul_we(pul_we), .pul_sel(pul_sel), .pul_data(pul_data),
    .sp_we(sp_we), .sp_out(sp_out), .stack_busy(stack_busy), .done(done)
  );

  assign rdata = regs[rsel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cen changes just after the active edge so it is stable at each negedge
  initial begin
    cen = 1'b1;
    forever begin
      @(posedge clk);
      #1 cen = cen_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Memory responder: acks after a random delay, checks each transaction
  initial begin
    logic [15:0] a1;
    int dly;
    logic armed;
    mem_ack = 1'b0; mem_din = 16'd0; dly = 0; armed = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0; armed = 1'b0;
      end else if (cen) begin
        if (mem_ack) mem_ack = 1'b0;
        else if (mem_req && resp_en) begin
          if (!armed) begin dly = $urandom_range(0, 2); armed = 1'b1; end
          if (dly > 0) dly--;
          else begin
            armed = 1'b0;
            if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
            else check("bus", {mem_we, mem_16, mem_addr, mem_we ? mem_dout : 16'h0},
                       exp_bus.pop_front());
            a1 = mem_addr + 16'd1;
            mem_din = mem_16 ? {mem[mem_addr], mem[a1]} : {8'h00, mem[mem_addr]};
            mem_ack = 1'b1;
          end
        end
      end
    end
  end

  // Strobe monitor: each registered strobe is counted once per cen cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cen) begin
        if (pul_we) begin
          if (exp_pul.size() == 0) check("pul_unexpected", 1, 0);
          else check("pul", {pul_sel, pul_data}, exp_pul.pop_front());
        end
        if (sp_we) begin
          if (exp_sp.size() == 0) check("sp_unexpected", 1, 0);
          else check("sp", sp_out, exp_sp.pop_front());
        end
        if (done) done_cnt++;
      end
    end
  end

  // Reference model: kind 0 psh_go, 1 pul_go, 2 psh_all, 3 psh_fast, 4 rti
  task automatic expect_op(input int kind, input logic [7:0] pb, input logic [15:0] sp0);
    logic [7:0] m;
    logic push, is_rti;
    logic [15:0] sp, a, a1, d;
    int b, sz;
    sp = sp0; is_rti = (kind == 4);
    push = (kind == 0) || (kind == 2) || (kind == 3);
    case (kind)
      0, 1:    m = pb;
      2:       m = 8'hFF;
      3:       m = 8'h81;
      default: m = 8'h01;
    endcase
    while (m != 8'd0) begin
      b = 0;
      if (push) begin for (int i = 0; i < 8; i++) if (m[i]) b = i; end
      else begin for (int i = 7; i >= 0; i--) if (m[i]) b = i; end
      sz = (b >= 4) ? 2 : 1;
      if (push) begin
        a = sp - 16'(sz);
        exp_bus.push_back({1'b1, sz == 2, a, regs[b]});
        sp = a;
      end else begin
        a = sp; a1 = sp + 16'd1;
        d = (sz == 2) ? {mem[a], mem[a1]} : {8'h00, mem[a]};
        exp_bus.push_back({1'b0, sz == 2, a, 16'h0});
        exp_pul.push_back({3'(b), d});
        sp = sp + 16'(sz);
      end
      exp_sp.push_back(sp);
      m[b] = 1'b0;
      if (is_rti && b == 0) m = m | (d[7] ? 8'hFE : 8'h80);
    end
    exp_done++;
    exp_sp_final = sp;
  endtask

  task automatic start_op(input int kind, input logic [7:0] pb, input logic [15:0] sp,
                          input logic [4:0] extra);
    logic [4:0] st;
    int n;
    expect_op(kind, pb, sp);
    case (kind)
      0:       st = 5'b00010;
      1:       st = 5'b00001;
      2:       st = 5'b01000;
      3:       st = 5'b00100;
      default: st = 5'b10000;
    endcase
    @(negedge clk);
    {rti, psh_all, psh_fast, psh_go, pul_go} = st | extra;
    postbyte = pb; sp_in = sp;
    n = 0;
    do begin @(negedge clk); n++; end while (!stack_busy && n < 200);
    check("start_accepted", stack_busy, 1'b1);
    {rti, psh_all, psh_fast, psh_go, pul_go} = 5'b0;
  endtask

  task automatic finish_op();
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 4000) begin @(negedge clk); #1; n++; end
    check("done_count", done_cnt, exp_done);
    n = 0;
    while (done && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic run_op(input int kind, input logic [7:0] pb, input logic [15:0] sp);
    start_op(kind, pb, sp, 5'b0);
    finish_op();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    {rti, psh_all, psh_fast, psh_go, pul_go} = 5'b0;
    postbyte = 8'h00; sp_in = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) regs[i] = (i < 4) ? {8'h00, 8'($urandom)} : 16'($urandom);
    #1;
    check("rst_outs", {mem_req, mem_we, mem_16, mem_addr, mem_dout, pul_we, pul_sel,
                       pul_data, sp_we, sp_out, stack_busy, done, rsel}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fast-interrupt frame: PC word then CC byte
    regs[7] = 16'h1234; regs[0] = 16'h0080;
    run_op(3, 8'h00, 16'h1000);
    check("fast_sp", sp_out, 16'h0FFD);

    // Pull A then B
    mem[16'h0FF0] = 8'h11; mem[16'h0FF1] = 8'h22;
    run_op(1, 8'h06, 16'h0FF0);
    check("pul_sp", sp_out, 16'h0FF2);

    // RTI with E set, then E clear
    mem[16'h2000] = 8'h80;
    run_op(4, 8'h00, 16'h2000);
    check("rti_e_sp", sp_out, 16'h200C);
    mem[16'h3000] = 8'h00;
    run_op(4, 8'h00, 16'h3000);
    check("rti_ne_sp", sp_out, 16'h3003);

    // Stack pointer wrap-around
    run_op(0, 8'h80, 16'h0001);
    check("wrap_sp", sp_out, 16'hFFFF);

    // Push beats pull when both arrive together; pul_go while busy is ignored
    start_op(0, 8'h30, 16'h4000, 5'b00001);
    pul_go = 1'b1;
    repeat (4) @(negedge clk);
    pul_go = 1'b0;
    finish_op();

    // Empty mask: done two cycles after the start cycle, no bus activity
    @(negedge clk);
    expect_op(0, 8'h00, 16'h5000);
    psh_go = 1'b1; postbyte = 8'h00; sp_in = 16'h5000;
    @(negedge clk);
    psh_go = 1'b0;
    check("empty_busy", {stack_busy, done, mem_req}, 3'b100);
    @(negedge clk);
    check("empty_done", {stack_busy, done, mem_req}, 3'b010);
    @(negedge clk);
    check("empty_idle", {done, mem_req}, 2'b00);
    check("empty_count", done_cnt, exp_done);

    // Reset while waiting on the bus
    resp_en = 1'b0;
    start_op(0, 8'h80, 16'h6000, 5'b0);
    n = 0;
    while (!mem_req && n < 100) begin @(negedge clk); n++; end
    check("rst_wait_req", mem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid", {mem_req, stack_busy, sp_we, pul_we, done}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_bus.delete(); exp_pul.delete(); exp_sp.delete();
    exp_done = done_cnt;
    resp_en = 1'b1;
    run_op(0, 8'h84, 16'h6000);
    check("post_rst_sp", sp_out, 16'h5FFD);

    // Random operations with a gated clock enable
    cen_rand = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 8; i++) regs[i] = (i < 4) ? {8'h00, 8'($urandom)} : 16'($urandom);
      run_op($urandom_range(0, 4), 8'($urandom), 16'($urandom));
      if (exp_sp.size() == 0 && exp_done == done_cnt) check("rand_sp", sp_out, exp_sp_final);
    end
    cen_rand = 1'b0;
    repeat (4) @(negedge clk);

    check("bus_q_empty", exp_bus.size(), 0);
    check("pul_q_empty", exp_pul.size(), 0);
    check("sp_q_empty", exp_sp.size(), 0);
    check("done_total", done_cnt, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
